pipeline_stall_control: RTL and testbench

Central stall sequencer for the five-stage pipeline. It merges stall requests from ID (load-use), EX (multi-cycle divide) and MEM (data-bus wait) into the 6-bit `stall` vector consumed by the PC and every inter-stage register, including `trans_ex_mem`. It owns the divide cycle counter and the memory wait/timeout counter, and clears both on an exception flush.

---
 rtl/pipeline_stall_control.sv | 122 ++++++++++++
 tb/tb_pipeline_stall_control.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_control.sv
// Central stall sequencer: merges ID/EX/MEM stall requests into the pipeline
// hold vector and owns the divide-cycle and memory-wait counters.
module pipeline_stall_control #(
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       id_stall_request,
  input  logic       ex_div_start,
  input  logic       mem_access,
  input  logic       mem_ready,
  output logic [5:0] stall,
  output logic       ex_div_done,
  output logic       mem_timeout,
  output logic       busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_LIMIT = CNT_W'(MEM_TIMEOUT);

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] div_count_q, div_count_d;
  logic [CNT_W-1:0] wait_count_q, wait_count_d;

  logic mem_wait;
  logic timeout_hit;
  logic mem_req;
  logic ex_req;

  // Request decode, stall priority, and next-state for both counters.
  always_comb begin
    state_d      = state_q;
    div_count_d  = div_count_q;
    wait_count_d = wait_count_q;
    stall        = STALL_NONE;

    mem_wait    = mem_access && !mem_ready;
    timeout_hit = (wait_count_q == MEM_LIMIT);
    mem_req     = mem_wait && !timeout_hit;
    ex_req      = ((state_q == S_IDLE) && ex_div_start) || (state_q == S_RUN);

    ex_div_done = reset && (state_q == S_DONE);
    busy        = reset && (state_q != S_IDLE);
    mem_timeout = reset && timeout_hit;

    if (reset && !flush) begin
      if (mem_req) begin
        stall = STALL_MEM;
      end else if (ex_req) begin
        stall = STALL_EX;
      end else if (id_stall_request) begin
        stall = STALL_ID;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ex_div_start) begin
          state_d     = S_RUN;
          div_count_d = DIV_LOAD;
        end
      end
      S_RUN: begin
        // Count runs regardless of stall; the last decrement lands in DONE.
        div_count_d = div_count_q - CNT_W'(1);
        if (div_count_q <= CNT_W'(1)) begin
          state_d     = S_DONE;
          div_count_d = '0;
        end
      end
      S_DONE: begin
        if (!stall[3]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        div_count_d = '0;
      end
    endcase

    // Wait counter clears on release and in the cycle after a timeout.
    if (!mem_wait || timeout_hit) begin
      wait_count_d = '0;
    end else begin
      wait_count_d = wait_count_q + CNT_W'(1);
    end

    if (flush) begin
      state_d      = S_IDLE;
      div_count_d  = '0;
      wait_count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      div_count_q  <= '0;
      wait_count_q <= '0;
    end else begin
      state_q      <= state_d;
      div_count_q  <= div_count_d;
      wait_count_q <= wait_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Randomized and directed bench for pipeline_stall_control against a
// cycle-indexed reference model of divide occupancy and memory waits.
module tb_pipeline_stall_control;

  localparam int unsigned DC = 32;
  localparam int unsigned MT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic       id_stall_request;
  logic       ex_div_start;
  logic       mem_access;
  logic       mem_ready;
  logic [5:0] stall;
  logic       ex_div_done;
  logic       mem_timeout;
  logic       busy;

  pipeline_stall_control #(
    .DIV_CYCLES (DC),
    .MEM_TIMEOUT(MT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .id_stall_request(id_stall_request),
    .ex_div_start    (ex_div_start),
    .mem_access      (mem_access),
    .mem_ready       (mem_ready),
    .stall           (stall),
    .ex_div_done     (ex_div_done),
    .mem_timeout     (mem_timeout),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a divide is a time window [t0, t0+DC) of EX hold, then done until released.
  int  cyc    = 0;
  bit  m_act  = 1'b0;
  int  m_t0   = 0;
  int  m_end  = 0;
  int  m_wait = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rs, input bit fl, input bit id, input bit st,
                      input bit ac, input bit rd);
    bit       e_exreq, e_done, e_to, e_mreq, e_busy;
    bit [5:0] e_stall;
    @(negedge clock);
    reset            = rs;
    flush            = fl;
    id_stall_request = id;
    ex_div_start     = st;
    mem_access       = ac;
    mem_ready        = rd;
    #1;
    e_exreq = (m_act && cyc < m_end) || (!m_act && st);
    e_done  = m_act && cyc >= m_end;
    e_to    = (m_wait == MT);
    e_mreq  = ac && !rd && !e_to;
    e_busy  = m_act && cyc > m_t0;
    if (!rs || fl)    e_stall = 6'b000000;
    else if (e_mreq)  e_stall = 6'b011111;
    else if (e_exreq) e_stall = 6'b001111;
    else if (id)      e_stall = 6'b000111;
    else              e_stall = 6'b000000;
    if (!rs) begin
      e_done = 1'b0;
      e_to   = 1'b0;
      e_busy = 1'b0;
    end
    check_val("stall",       8'(stall),       8'(e_stall));
    check_val("ex_div_done", 8'(ex_div_done), 8'(e_done));
    check_val("mem_timeout", 8'(mem_timeout), 8'(e_to));
    check_val("busy",        8'(busy),        8'(e_busy));
    // Advance the model to the next cycle.
    if (!rs || fl) begin
      m_act = 1'b0;
    end else if (m_act && cyc >= m_end) begin
      if (!e_stall[3]) m_act = 1'b0;
    end else if (!m_act && st) begin
      m_act = 1'b1;
      m_t0  = cyc;
      m_end = cyc + DC;
    end
    if (!rs || fl || !ac || rd || m_wait == MT) m_wait = 0;
    else                                        m_wait = m_wait + 1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int burst;
    bit ac, rd;
    reset = 1'b0; flush = 1'b0; id_stall_request = 1'b0;
    ex_div_start = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 1, 0, 0, 0);
    idle(2);

    // Divide with a redundant start at T0+5.
    step(1, 0, 0, 1, 0, 0);
    for (int i = 1; i < DC + 6; i++) step(1, 0, 0, (i == 5), 0, 0);

    // Short memory wait, then timeout.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    idle(2);
    for (int i = 0; i < MT + 2; i++) step(1, 0, 0, 0, 1, 0);
    idle(2);

    // Divide reaching DONE under a memory wait.
    step(1, 0, 0, 1, 0, 0);
    for (int i = 1; i < 30; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 30; i < 33; i++) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    idle(3);

    // Flush mid-divide, immediate restart, then reset mid-divide and restart.
    step(1, 0, 0, 1, 0, 0);
    idle(9);
    step(1, 1, 0, 1, 1, 0);
    step(1, 0, 0, 1, 0, 0);
    idle(9);
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 0, 0);
    idle(DC + 3);

    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) begin
        ac = 1'b1; rd = 1'b0; burst--;
      end else begin
        ac = ($urandom_range(0, 99) < 35);
        rd = ($urandom_range(0, 99) < 30);
        if ($urandom_range(0, 99) < 3) burst = $urandom_range(2, 7);
      end
      step($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, ac, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
